// File: rtl/nasti_rd_burst_arbiter.sv
// nasti_rd_burst_arbiter
// Two-requester NASTI read-channel arbiter with one burst outstanding on the
// shared slave. Tie-break is fixed (requester 0 wins) by default.
// Define NASTI_RD_ARB_ROUND_ROBIN_EN to alternate ties instead. In that mode
// the requester that was not served last wins.
//
// state | meaning
// IDLE  | no owner, arbitrate pending AR requests
// ADDR  | owner's AR forwarded to slave, waiting for AR handshake
// DATA  | slave R beats routed to owner until last beat accepted
module nasti_rd_burst_arbiter #(
   parameter int ID_WIDTH   = 1,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [ID_WIDTH-1:0]   m0_ar_id,
   input  logic [ADDR_WIDTH-1:0] m0_ar_addr,
   input  logic [7:0]            m0_ar_len,
   input  logic [2:0]            m0_ar_size,
   input  logic [1:0]            m0_ar_burst,
   input  logic                  m0_ar_lock,
   input  logic [3:0]            m0_ar_cache,
   input  logic [2:0]            m0_ar_prot,
   input  logic [3:0]            m0_ar_qos,
   input  logic [3:0]            m0_ar_region,
   input  logic [USER_WIDTH-1:0] m0_ar_user,
   input  logic                  m0_ar_valid,
   output logic                  m0_ar_ready,
   input  logic [ID_WIDTH-1:0]   m1_ar_id,
   input  logic [ADDR_WIDTH-1:0] m1_ar_addr,
   input  logic [7:0]            m1_ar_len,
   input  logic [2:0]            m1_ar_size,
   input  logic [1:0]            m1_ar_burst,
   input  logic                  m1_ar_lock,
   input  logic [3:0]            m1_ar_cache,
   input  logic [2:0]            m1_ar_prot,
   input  logic [3:0]            m1_ar_qos,
   input  logic [3:0]            m1_ar_region,
   input  logic [USER_WIDTH-1:0] m1_ar_user,
   input  logic                  m1_ar_valid,
   output logic                  m1_ar_ready,
   output logic [ID_WIDTH-1:0]   m0_r_id,
   output logic [DATA_WIDTH-1:0] m0_r_data,
   output logic [1:0]            m0_r_resp,
   output logic                  m0_r_last,
   output logic [USER_WIDTH-1:0] m0_r_user,
   output logic                  m0_r_valid,
   input  logic                  m0_r_ready,
   output logic [ID_WIDTH-1:0]   m1_r_id,
   output logic [DATA_WIDTH-1:0] m1_r_data,
   output logic [1:0]            m1_r_resp,
   output logic                  m1_r_last,
   output logic [USER_WIDTH-1:0] m1_r_user,
   output logic                  m1_r_valid,
   input  logic                  m1_r_ready,
   output logic [ID_WIDTH-1:0]   s_ar_id,
   output logic [ADDR_WIDTH-1:0] s_ar_addr,
   output logic [7:0]            s_ar_len,
   output logic [2:0]            s_ar_size,
   output logic [1:0]            s_ar_burst,
   output logic                  s_ar_lock,
   output logic [3:0]            s_ar_cache,
   output logic [2:0]            s_ar_prot,
   output logic [3:0]            s_ar_qos,
   output logic [3:0]            s_ar_region,
   output logic [USER_WIDTH-1:0] s_ar_user,
   output logic                  s_ar_valid,
   input  logic                  s_ar_ready,
   input  logic [ID_WIDTH-1:0]   s_r_id,
   input  logic [DATA_WIDTH-1:0] s_r_data,
   input  logic [1:0]            s_r_resp,
   input  logic                  s_r_last,
   input  logic [USER_WIDTH-1:0] s_r_user,
   input  logic                  s_r_valid,
   output logic                  s_r_ready,
   output logic [1:0]            gnt,
   output logic                  busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;

   logic [1:0] state;
   logic [1:0] pick;
   logic       in_addr;
   logic       in_data;
   logic       r_done;

   assign in_addr = (state == ADDR);
   assign in_data = (state == DATA);
   assign busy    = (state != IDLE);
   assign r_done  = in_data & s_r_valid & s_r_ready & s_r_last;

`ifdef NASTI_RD_ARB_ROUND_ROBIN_EN
   logic prio1;

   // remember who should win the next tie: the one not just served
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)       prio1 <= 1'b0;
      else if (r_done) prio1 <= gnt[0];
   end

   // round-robin tie-break between simultaneous requests
   always_comb begin
      pick = 2'b01;
      if (m1_ar_valid && (!m0_ar_valid || prio1)) pick = 2'b10;
   end
`else
   // fixed priority: requester 0 wins any tie
   always_comb begin
      pick = 2'b01;
      if (!m0_ar_valid) pick = 2'b10;
   end
`endif

   // sequencer: one owner from grant through last R beat
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         gnt   <= 2'b00;
      end else begin
         case (state)
            IDLE: if (m0_ar_valid || m1_ar_valid) begin
               gnt   <= pick;
               state <= ADDR;
            end
            ADDR: if (s_ar_valid && s_ar_ready) state <= DATA;
            DATA: if (r_done) begin
               gnt   <= 2'b00;
               state <= IDLE;
            end
            default: begin
               gnt   <= 2'b00;
               state <= IDLE;
            end
         endcase
      end
   end

   // AR mux: payload follows the grant; valid/ready only in ADDR
   always_comb begin
      {s_ar_id, s_ar_addr, s_ar_len, s_ar_size, s_ar_burst, s_ar_lock,
       s_ar_cache, s_ar_prot, s_ar_qos, s_ar_region, s_ar_user} =
         gnt[1] ?
         {m1_ar_id, m1_ar_addr, m1_ar_len, m1_ar_size, m1_ar_burst, m1_ar_lock,
          m1_ar_cache, m1_ar_prot, m1_ar_qos, m1_ar_region, m1_ar_user} :
         {m0_ar_id, m0_ar_addr, m0_ar_len, m0_ar_size, m0_ar_burst, m0_ar_lock,
          m0_ar_cache, m0_ar_prot, m0_ar_qos, m0_ar_region, m0_ar_user};
      s_ar_valid  = in_addr & ((gnt[0] & m0_ar_valid) | (gnt[1] & m1_ar_valid));
      m0_ar_ready = in_addr & gnt[0] & s_ar_ready;
      m1_ar_ready = in_addr & gnt[1] & s_ar_ready;
   end

   // R demux: payload broadcast, valid/ready qualified by owner in DATA
   always_comb begin
      m0_r_id    = s_r_id;
      m0_r_data  = s_r_data;
      m0_r_resp  = s_r_resp;
      m0_r_last  = s_r_last;
      m0_r_user  = s_r_user;
      m1_r_id    = s_r_id;
      m1_r_data  = s_r_data;
      m1_r_resp  = s_r_resp;
      m1_r_last  = s_r_last;
      m1_r_user  = s_r_user;
      m0_r_valid = in_data & gnt[0] & s_r_valid;
      m1_r_valid = in_data & gnt[1] & s_r_valid;
      s_r_ready  = in_data & ((gnt[0] & m0_r_ready) | (gnt[1] & m1_r_ready));
   end

endmodule
